// File: rtl/serial_pkg.sv
// Shared definitions for the serial link receiver and transmitter.
// The PAR state exists only when SERIAL_RX_PARITY_EN is defined.
package serial_pkg;

    localparam int   DEF_DATA_W = 8;
    localparam logic START_LVL  = 1'b1;

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PAR} rx_state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA} rx_state_t;
`endif

endpackage

// File: rtl/serial_rx.sv
// Serial frame receiver: start bit, DATA_W bits MSB first, optional even parity bit.
// Optional parity checking and the ParErr port are enabled with SERIAL_RX_PARITY_EN.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              SDin,
    output logic [DATA_W-1:0] PDout,
    output logic              Valid,
    output logic              Busy,
`ifdef SERIAL_RX_PARITY_EN
    output logic              ParErr,
`endif
    output logic [7:0]        FrameCnt
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    rx_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              word_done;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift;
        word_done = 1'b0;
        case (state)
            IDLE: begin
                if (SDin == START_LVL) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                shift_nxt = {shift[DATA_W-2:0], SDin};
                cnt_nxt   = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    cnt_nxt = '0;
`ifdef SERIAL_RX_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = IDLE;
                    word_done = 1'b1;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PAR: begin
                state_nxt = IDLE;
                word_done = 1'b1;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: shift_nxt already holds the full word on the completing edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt      <= '0;
            shift    <= '0;
            PDout    <= '0;
            Valid    <= 1'b0;
            FrameCnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
            ParErr   <= 1'b0;
`endif
        end else begin
            cnt   <= cnt_nxt;
            shift <= shift_nxt;
            Valid <= word_done;
            if (word_done) begin
                PDout    <= shift_nxt;
                FrameCnt <= FrameCnt + 8'd1;
`ifdef SERIAL_RX_PARITY_EN
                ParErr   <= (SDin != ^shift);
`endif
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: directed frames plus randomized streams against a frame-parsing model.
module tb_serial_rx;

    localparam int DW = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = 1 + DW + P;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          SDin = 1'b0;
    logic [DW-1:0] PDout;
    logic          Valid;
    logic          Busy;
    logic [7:0]    FrameCnt;
`ifdef SERIAL_RX_PARITY_EN
    logic          ParErr;
`endif

    int nvec = 0;
    int nerr = 0;

    bit            stim[$];
    logic          obs_v[$], obs_b[$], obs_pe[$];
    logic [DW-1:0] obs_pd[$];
    logic [7:0]    obs_fc[$];
    logic          exp_v[], exp_b[], exp_pe[];
    logic [DW-1:0] exp_pd[];
    logic [7:0]    exp_fc[];

    serial_rx #(.DATA_W(DW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .SDin     (SDin),
        .PDout    (PDout),
        .Valid    (Valid),
        .Busy     (Busy),
`ifdef SERIAL_RX_PARITY_EN
        .ParErr   (ParErr),
`endif
        .FrameCnt (FrameCnt)
    );

    always #5 Clk = ~Clk;

    function automatic logic cur_perr();
`ifdef SERIAL_RX_PARITY_EN
        return ParErr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        Rst  = 1'b1;
        SDin = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic push_frame(input logic [DW-1:0] w, input bit pbit);
        stim.push_back(1'b1);
        for (int j = DW - 1; j >= 0; j--) stim.push_back(w[j]);
        if (P == 1) stim.push_back(pbit);
    endtask

    task automatic run_stream();
        obs_v.delete(); obs_b.delete(); obs_pd.delete(); obs_fc.delete(); obs_pe.delete();
        foreach (stim[k]) begin
            SDin = stim[k];
            @(posedge Clk);
            #1;
            obs_v.push_back(Valid);
            obs_b.push_back(Busy);
            obs_pd.push_back(PDout);
            obs_fc.push_back(FrameCnt);
            obs_pe.push_back(cur_perr());
        end
        SDin = 1'b0;
    endtask

    // Reference: parse the bit stream into frames (a 1 outside a frame starts one).
    task automatic build_model();
        int            n, i;
        logic [DW-1:0] w, pd;
        logic          pe;
        logic [7:0]    fc;
        bit            ev[];
        logic [DW-1:0] evw[];
        logic          evp[];
        n = stim.size();
        ev = new[n]; evw = new[n]; evp = new[n];
        exp_v = new[n]; exp_b = new[n]; exp_pd = new[n]; exp_fc = new[n]; exp_pe = new[n];
        for (int k = 0; k < n; k++) begin
            ev[k] = 1'b0; evw[k] = '0; evp[k] = 1'b0; exp_b[k] = 1'b0;
        end
        i = 0;
        while (i < n) begin
            if (!stim[i]) begin
                i++;
            end else begin
                for (int j = i; j <= i + FL - 2 && j < n; j++) exp_b[j] = 1'b1;
                if (i + FL - 1 < n) begin
                    w = '0;
                    for (int j = 1; j <= DW; j++) w[DW-j] = stim[i+j];
                    ev[i+FL-1]  = 1'b1;
                    evw[i+FL-1] = w;
                    evp[i+FL-1] = (P == 1 && (stim[i+FL-1] != ^w));
                    i += FL;
                end else begin
                    i = n;
                end
            end
        end
        pd = '0; pe = 1'b0; fc = 8'd0;
        for (int k = 0; k < n; k++) begin
            if (ev[k]) begin
                pd = evw[k];
                pe = evp[k];
                fc = fc + 8'd1;
            end
            exp_v[k] = ev[k]; exp_pd[k] = pd; exp_pe[k] = pe; exp_fc[k] = fc;
        end
    endtask

    task automatic test_reset();
        do_reset();
        stim.delete();
        push_frame(8'hC3, 1'b1);
        run_stream();
        Rst  = 1'b1;
        SDin = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        nvec++; if (PDout !== '0) begin nerr++; $display("FAIL reset_pdout: got %h want 00", PDout); end
        nvec++; if (Valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", Valid); end
        nvec++; if (Busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", Busy); end
        nvec++; if (FrameCnt !== 8'd0) begin nerr++; $display("FAIL reset_framecnt: got %0d want 0", FrameCnt); end
        nvec++; if (cur_perr() !== 1'b0) begin nerr++; $display("FAIL reset_parerr: got %b want 0", cur_perr()); end
        Rst  = 1'b0;
        SDin = 1'b0;
    endtask

    task automatic test_idle();
        do_reset();
        stim.delete();
        repeat (20) stim.push_back(1'b0);
        run_stream();
        foreach (obs_v[k]) begin
            nvec++;
            if (obs_v[k] !== 1'b0 || obs_b[k] !== 1'b0) begin
                nerr++; $display("FAIL idle_cycle%0d: got valid=%b busy=%b want 0 0", k, obs_v[k], obs_b[k]);
            end
        end
        nvec++; if (FrameCnt !== 8'd0) begin nerr++; $display("FAIL idle_framecnt: got %0d want 0", FrameCnt); end
    endtask

    task automatic test_single();
        int nv, pos;
        do_reset();
        stim.delete();
        push_frame(8'hA5, 1'b0);
        repeat (3) stim.push_back(1'b0);
        run_stream();
        nv = 0; pos = -1;
        foreach (obs_v[k]) if (obs_v[k] === 1'b1) begin nv++; if (pos < 0) pos = k; end
        nvec++; if (nv != 1) begin nerr++; $display("FAIL a5_pulses: got %0d want 1", nv); end
        nvec++; if (pos != FL - 1) begin nerr++; $display("FAIL a5_valid_pos: got %0d want %0d", pos, FL - 1); end
        nvec++; if (obs_pd[FL-1] !== 8'hA5) begin nerr++; $display("FAIL a5_pdout: got %h want a5", obs_pd[FL-1]); end
        nvec++; if (obs_fc[FL-1] !== 8'd1) begin nerr++; $display("FAIL a5_framecnt: got %0d want 1", obs_fc[FL-1]); end
        nvec++;
        if (obs_b[0] !== 1'b1 || obs_b[FL-2] !== 1'b1 || obs_b[FL-1] !== 1'b0) begin
            nerr++; $display("FAIL a5_busy: got %b%b%b want 110", obs_b[0], obs_b[FL-2], obs_b[FL-1]);
        end
        nvec++; if (obs_pd[FL+2] !== 8'hA5) begin nerr++; $display("FAIL a5_hold: got %h want a5", obs_pd[FL+2]); end
    endtask

    task automatic test_back_to_back();
        int nv;
        do_reset();
        stim.delete();
        push_frame(8'h3C, 1'b0);
        push_frame(8'hFF, 1'b0);
        repeat (2) stim.push_back(1'b0);
        run_stream();
        nv = 0;
        foreach (obs_v[k]) if (obs_v[k] === 1'b1) nv++;
        nvec++; if (nv != 2) begin nerr++; $display("FAIL b2b_pulses: got %0d want 2", nv); end
        nvec++; if (obs_v[FL-1] !== 1'b1 || obs_pd[FL-1] !== 8'h3C) begin
            nerr++; $display("FAIL b2b_first: got v=%b pd=%h want 1 3c", obs_v[FL-1], obs_pd[FL-1]); end
        nvec++; if (obs_pd[2*FL-2] !== 8'h3C) begin nerr++; $display("FAIL b2b_hold: got %h want 3c", obs_pd[2*FL-2]); end
        nvec++; if (obs_v[2*FL-1] !== 1'b1 || obs_pd[2*FL-1] !== 8'hFF) begin
            nerr++; $display("FAIL b2b_second: got v=%b pd=%h want 1 ff", obs_v[2*FL-1], obs_pd[2*FL-1]); end
        nvec++; if (obs_fc[2*FL] !== 8'd2) begin nerr++; $display("FAIL b2b_framecnt: got %0d want 2", obs_fc[2*FL]); end
    endtask

    task automatic test_reset_midframe();
        int  nv;
        bit  lastb;
        do_reset();
        stim.delete();
        stim.push_back(1'b1);
        repeat (4) stim.push_back(1'b1);
        run_stream();
        nv = 0;
        foreach (obs_v[k]) if (obs_v[k] === 1'b1) nv++;
        nvec++; if (nv != 0 || obs_b[4] !== 1'b1) begin
            nerr++; $display("FAIL mid_partial: got pulses=%0d busy=%b want 0 1", nv, obs_b[4]); end
        Rst = 1'b1; SDin = 1'b1;
        @(posedge Clk); #1;
        nvec++; if (Valid !== 1'b0 || Busy !== 1'b0) begin
            nerr++; $display("FAIL mid_rst: got valid=%b busy=%b want 0 0", Valid, Busy); end
        Rst = 1'b0;
        stim.delete();
        push_frame(8'h81, 1'b0);
        repeat (2) stim.push_back(1'b0);
        run_stream();
        nvec++; if (obs_v[FL-1] !== 1'b1 || obs_pd[FL-1] !== 8'h81 || obs_fc[FL-1] !== 8'd1) begin
            nerr++; $display("FAIL mid_next: got v=%b pd=%h fc=%0d want 1 81 1", obs_v[FL-1], obs_pd[FL-1], obs_fc[FL-1]); end
        // Rst arriving together with the final frame bit.
        stim.delete();
        push_frame(8'h5B, 1'b1);
        lastb = stim.pop_back();
        run_stream();
        Rst = 1'b1; SDin = lastb;
        @(posedge Clk); #1;
        nvec++; if (Valid !== 1'b0 || FrameCnt !== 8'd0 || PDout !== '0) begin
            nerr++; $display("FAIL rst_last_bit: got v=%b fc=%0d pd=%h want 0 0 00", Valid, FrameCnt, PDout); end
        Rst = 1'b0; SDin = 1'b0;
        @(posedge Clk); #1;
        nvec++; if (Valid !== 1'b0 || Busy !== 1'b0) begin
            nerr++; $display("FAIL rst_last_after: got v=%b busy=%b want 0 0", Valid, Busy); end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        do_reset();
        stim.delete();
        push_frame(8'h07, 1'b1);
        push_frame(8'h07, 1'b0);
        repeat (2) stim.push_back(1'b0);
        run_stream();
        nvec++; if (obs_v[9] !== 1'b1 || obs_pe[9] !== 1'b0 || obs_pd[9] !== 8'h07) begin
            nerr++; $display("FAIL par_good: got v=%b pe=%b pd=%h want 1 0 07", obs_v[9], obs_pe[9], obs_pd[9]); end
        nvec++; if (obs_v[19] !== 1'b1 || obs_pe[19] !== 1'b1 || obs_pd[19] !== 8'h07) begin
            nerr++; $display("FAIL par_bad: got v=%b pe=%b pd=%h want 1 1 07", obs_v[19], obs_pe[19], obs_pd[19]); end
        nvec++; if (obs_pe[21] !== 1'b1) begin nerr++; $display("FAIL par_hold: got %b want 1", obs_pe[21]); end
    endtask
`endif

    task automatic test_wrap();
        int nv;
        do_reset();
        stim.delete();
        repeat (256) push_frame(8'h00, 1'b0);
        stim.push_back(1'b0);
        run_stream();
        nv = 0;
        foreach (obs_v[k]) if (obs_v[k] === 1'b1) nv++;
        nvec++; if (nv != 256) begin nerr++; $display("FAIL wrap_pulses: got %0d want 256", nv); end
        nvec++; if (obs_fc[255*FL-1] !== 8'd255) begin nerr++; $display("FAIL wrap_255: got %0d want 255", obs_fc[255*FL-1]); end
        nvec++; if (FrameCnt !== 8'd0 || PDout !== 8'h00) begin
            nerr++; $display("FAIL wrap_final: got fc=%0d pd=%h want 0 00", FrameCnt, PDout); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            stim.delete();
            if (r < 2) begin
                for (int f = 0; f < 40; f++) begin
                    repeat ($urandom_range(0, 3)) stim.push_back(1'b0);
                    push_frame(DW'($urandom), bit'($urandom_range(0, 1)));
                end
                stim.push_back(1'b0);
            end else begin
                repeat (400) stim.push_back(bit'($urandom_range(0, 1)));
            end
            build_model();
            run_stream();
            for (int k = 0; k < stim.size(); k++) begin
                nvec++;
                if (obs_v[k] !== exp_v[k] || obs_b[k] !== exp_b[k] || obs_pd[k] !== exp_pd[k] ||
                    obs_fc[k] !== exp_fc[k] || obs_pe[k] !== exp_pe[k]) begin
                    nerr++;
                    $display("FAIL rand%0d_cycle%0d: got v=%b b=%b pd=%h fc=%0d pe=%b want v=%b b=%b pd=%h fc=%0d pe=%b",
                             r, k, obs_v[k], obs_b[k], obs_pd[k], obs_fc[k], obs_pe[k],
                             exp_v[k], exp_b[k], exp_pd[k], exp_fc[k], exp_pe[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_reset_midframe();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
